bbox_overlay_stream: RTL and testbench
======================================

Name: bbox_overlay_stream

Overview:
- Streaming, synthesizable successor to the file-based bounding-box overlay stage in the face-detection flow.
- Holds a per-tile detection mask: one bit per BLK x BLK tile of the image, padded up to a multiple of BLK.
- Accepts the original image as a raster pixel stream and emits it with detected tiles marked in one of three modes: pass, fill or tile-outline.
- Sits between the detector (mask producer) and the frame writer.

Parameters:
- PIX_W, 8, pixel bit width.
- BLK, 8, tile edge in pixels; must be a power of 2, at least 2.
- MAX_W, 1024, maximum image width in pixels.
- MAX_H, 1024, maximum image height in pixels.
- MAX_TILES, (MAX_W/BLK)*(MAX_H/BLK), mask memory depth in bits.
- DIM_W, $clog2(MAX_W>MAX_H?MAX_W:MAX_H)+1, width of the dimension ports.
- TA_W, $clog2(MAX_TILES), width of the tile address.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cfg_width  in  DIM_W  image width; sampled on start.
- cfg_height  in  DIM_W  image height; sampled on start.
- cfg_mode  in  2  0=pass, 1=fill, 2=outline, 3=reserved (treated as pass); sampled on start.
- cfg_mark  in  PIX_W  marker pixel value; sampled on start.
- start  in  1  one-cycle pulse that begins a frame.
- mask_we  in  1  mask bit write strobe.
- mask_addr  in  TA_W  tile index = ty*tiles_per_row + tx.
- mask_din  in  1  detection bit.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  input pixel ready.
- in_pix  in  PIX_W  original pixel, raster order.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream ready.
- out_pix  out  PIX_W  overlaid pixel.
- out_last  out  1  asserted with the final pixel of the frame.
- busy  out  1  high while in STREAM or DRAIN.
- frame_done  out  1  one-cycle pulse when the frame completes.
- cfg_err  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset values: out_valid, out_last, busy, frame_done, cfg_err = 0; in_ready = 0; all counters = 0; FSM = IDLE.
- Mask memory is not reset; the host writes every tile used by the frame.
- FSM states: IDLE, STREAM, DRAIN.
- IDLE:
  - mask_we writes mask[mask_addr] <= mask_din.
  - On start:
    - If cfg_width==0, cfg_height==0, cfg_width>MAX_W or cfg_height>MAX_H: pulse cfg_err next cycle and remain in IDLE.
    - Otherwise latch the configuration, compute tiles_per_row = ceil(width/BLK) by shift, clear counters and go to STREAM.
- STREAM:
  - in_ready = !out_valid || out_ready.
  - mask_we is ignored.
  - start is ignored.
- Pixel counters and tile index:
  - x in 0..width-1, y in 0..height-1.
  - tx = x>>log2(BLK), ty = y>>log2(BLK).
  - Tile index = row_base + tx. row_base increases by tiles_per_row each time y crosses a BLK boundary. No multiplier is used.
- Mark rule for accepted pixel (x,y), with hit = mask[tile index]:
  - pass: out = in.
  - fill: out = hit ? cfg_mark : in.
  - outline: out = cfg_mark when hit and the pixel is on its tile's edge (x%BLK==0, x%BLK==BLK-1, x==width-1, y%BLK==0, y%BLK==BLK-1 or y==height-1) and the neighbouring tile across that edge is unset or outside the image; otherwise out = in.
  - Outline needs up to 4 neighbour reads. The mask is built as asynchronous-read distributed memory with 5 read ports, or replicated.
- Latency and flow control:
  - Latency is exactly 1 cycle from the input handshake to out_valid.
  - The output register holds while out_valid && !out_ready.
  - No pixel is dropped or duplicated under any backpressure pattern.
- End of frame:
  - When the pixel at (width-1, height-1) is accepted, its output carries out_last=1 and the FSM goes to DRAIN.
  - In DRAIN, in_ready=0.
  - When that output handshakes, go to IDLE and pulse frame_done in the same cycle. busy falls on the next cycle.
- Partial tiles: the right and bottom tiles may be partial. Padded pixels never appear on the stream, and padded area counts as outside the image for outline.
- Reset mid-frame returns the block to IDLE within one clock: the output is discarded and out_valid = 0.

Decomposition:
- Shared package bbox_pkg:
  - mode encodings MODE_PASS=0, MODE_FILL=1, MODE_OUTLINE=2;
  - state enum {IDLE, STREAM, DRAIN};
  - localparam helper for the log2(BLK) shift.
- One sub-module, bbox_tile_mask: MAX_TILES x 1 memory with one write port and 5 asynchronous read ports (centre, left, right, up, down). Out-of-range addresses return 0.

Test Plan:
- Fill, all mask bits written 0, 16x16 ramp with in_pix = x+16y, out_ready=1 -> output equals input; 256 pixels; out_last only on pixel 255; frame_done=1 once.
- Fill, 10x10, BLK=8, only tile 3 (tx=1, ty=1) set, mark=255 -> pixels x,y in 8..9 read 255, all others pass through; tiles_per_row=2 confirmed.
- Outline, 24x24, tiles (0,0) and (1,0) set -> row y=0 for x=0..15, column x=0, column x=15 and row y=7 for x=0..15 read 255; x=7 and x=8 are unmarked because the neighbour is set.
- Backpressure: out_ready random at 30%, 16x16 fill -> exact 256-pixel sequence matches the model; in_ready=0 whenever out_valid && !out_ready.
- start with cfg_width=0, then start with cfg_height=MAX_H+1 -> cfg_err pulses twice, busy stays 0.
- Reset asserted after 50 pixels, then a fresh start with the same configuration -> out_valid=0 the cycle after reset; the second frame is complete and correct.

Source files
------------

// File: rtl/bbox_pkg.sv
// bbox_pkg: shared encodings and helpers for the bounding-box overlay stream
//   MODE_*     : overlay mode encodings carried on cfg_mode
//   state_t    : frame sequencer states
//   blk_shift  : log2 of the tile edge, used to turn divides by BLK into shifts
package bbox_pkg;

    localparam logic [1:0] MODE_PASS    = 2'd0;
    localparam logic [1:0] MODE_FILL    = 2'd1;
    localparam logic [1:0] MODE_OUTLINE = 2'd2;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    function automatic int blk_shift(input int blk);
        return $clog2(blk);
    endfunction

endpackage

// File: rtl/bbox_tile_mask.sv
// bbox_tile_mask: per-tile detection bit memory, one write port and five asynchronous read ports
//   clk      : clock for the write port
//   i_we     : write strobe; i_waddr/i_wdata give the tile and its bit
//   i_raddr  : read addresses (centre, left, right, up, down)
//   o_rdata  : read bits in the same order; addresses past MAX_TILES read as 0
module bbox_tile_mask #(
    parameter int MAX_TILES = 16384,
    parameter int TA_W      = $clog2(MAX_TILES)
) (
    input  logic            clk,
    input  logic            i_we,
    input  logic [TA_W-1:0] i_waddr,
    input  logic            i_wdata,
    input  logic [TA_W-1:0] i_raddr [5],
    output logic [4:0]      o_rdata
);

    logic r_mem [MAX_TILES];

    always_ff @(posedge clk)
        if (i_we && ({1'b0, i_waddr} < (TA_W+1)'(MAX_TILES)))
            r_mem[i_waddr] <= i_wdata;

    for (genvar g = 0; g < 5; g++) begin : g_rd
        assign o_rdata[g] = ({1'b0, i_raddr[g]} < (TA_W+1)'(MAX_TILES)) ? r_mem[i_raddr[g]] : 1'b0;
    end

endmodule

// File: rtl/bbox_overlay_stream.sv
// bbox_overlay_stream: marks detected tiles on a raster pixel stream (pass / fill / tile-outline)
//   cfg_width/cfg_height/cfg_mode/cfg_mark : frame configuration, sampled on start
//   start                                  : begins a frame; rejected configs pulse cfg_err
//   mask_we/mask_addr/mask_din             : tile mask writes, honoured only while idle
//   in_valid/in_ready/in_pix               : raster input stream
//   out_valid/out_ready/out_pix/out_last   : overlaid output stream, one register stage
//   busy/frame_done/cfg_err                : frame status
module bbox_overlay_stream
    import bbox_pkg::*;
#(
    parameter int PIX_W     = 8,
    parameter int BLK       = 8,
    parameter int MAX_W     = 1024,
    parameter int MAX_H     = 1024,
    parameter int MAX_TILES = (MAX_W/BLK)*(MAX_H/BLK),
    parameter int DIM_W     = $clog2(MAX_W > MAX_H ? MAX_W : MAX_H) + 1,
    parameter int TA_W      = $clog2(MAX_TILES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIM_W-1:0] cfg_width,
    input  logic [DIM_W-1:0] cfg_height,
    input  logic [1:0]       cfg_mode,
    input  logic [PIX_W-1:0] cfg_mark,
    input  logic             start,
    input  logic             mask_we,
    input  logic [TA_W-1:0]  mask_addr,
    input  logic             mask_din,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pix,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_pix,
    output logic             out_last,
    output logic             busy,
    output logic             frame_done,
    output logic             cfg_err
);

    localparam int SH = blk_shift(BLK);

    state_t           r_state, w_next;
    logic [DIM_W-1:0] r_width, r_height, r_tpr, r_x, r_y;
    logic [1:0]       r_mode;
    logic [PIX_W-1:0] r_mark, r_out_pix;
    logic [TA_W-1:0]  r_row_base;
    logic             r_out_valid, r_out_last, r_cfg_err;

    logic             w_cfg_bad, w_start_ok, w_acc, w_x_end, w_y_end;
    logic [TA_W-1:0]  w_idx;
    logic [TA_W-1:0]  w_raddr [5];
    logic [4:0]       w_rd;
    logic             w_l_edge, w_r_edge, w_u_edge, w_d_edge;
    logic             w_l_nb, w_r_nb, w_u_nb, w_d_nb;
    logic             w_outline, w_mark;

    assign w_cfg_bad  = cfg_width == '0 || cfg_height == '0 ||
                        cfg_width > DIM_W'(MAX_W) || cfg_height > DIM_W'(MAX_H);
    assign w_start_ok = r_state == IDLE && start && !w_cfg_bad;
    assign w_acc      = in_valid && in_ready;
    assign w_x_end    = r_x == r_width - DIM_W'(1);
    assign w_y_end    = r_y == r_height - DIM_W'(1);

    // row_base tracks ty*tiles_per_row incrementally, so no multiplier is needed
    assign w_idx      = r_row_base + TA_W'(r_x >> SH);
    assign w_raddr[0] = w_idx;
    assign w_raddr[1] = w_idx - TA_W'(1);
    assign w_raddr[2] = w_idx + TA_W'(1);
    assign w_raddr[3] = w_idx - TA_W'(r_tpr);
    assign w_raddr[4] = w_idx + TA_W'(r_tpr);

    bbox_tile_mask #(.MAX_TILES(MAX_TILES), .TA_W(TA_W)) u_mask (
        .clk     (clk),
        .i_we    (mask_we && r_state == IDLE),
        .i_waddr (mask_addr),
        .i_wdata (mask_din),
        .i_raddr (w_raddr),
        .o_rdata (w_rd)
    );

    // a neighbour only counts if its tile lies inside the image; the padded
    // area beyond the last column/row behaves like an unset tile
    assign w_l_edge  = r_x[SH-1:0] == '0;
    assign w_r_edge  = &r_x[SH-1:0] || w_x_end;
    assign w_u_edge  = r_y[SH-1:0] == '0;
    assign w_d_edge  = &r_y[SH-1:0] || w_y_end;
    assign w_l_nb    = r_x >= DIM_W'(BLK) && w_rd[1];
    assign w_r_nb    = !w_x_end && w_rd[2];
    assign w_u_nb    = r_y >= DIM_W'(BLK) && w_rd[3];
    assign w_d_nb    = !w_y_end && w_rd[4];
    assign w_outline = w_rd[0] && ((w_l_edge && !w_l_nb) || (w_r_edge && !w_r_nb) ||
                                   (w_u_edge && !w_u_nb) || (w_d_edge && !w_d_nb));
    assign w_mark    = (r_mode == MODE_FILL && w_rd[0]) || (r_mode == MODE_OUTLINE && w_outline);

    always_ff @(posedge clk)
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;

    always_comb begin
        w_next     = r_state;
        in_ready   = 1'b0;
        frame_done = 1'b0;
        case (r_state)
            IDLE:    w_next = w_start_ok ? STREAM : IDLE;
            STREAM: begin
                in_ready = !r_out_valid || out_ready;
                w_next   = (in_valid && in_ready && w_x_end && w_y_end) ? DRAIN : STREAM;
            end
            DRAIN: begin
                frame_done = r_out_valid && out_ready;
                w_next     = frame_done ? IDLE : DRAIN;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        if (reset) begin
            r_width     <= '0;
            r_height    <= '0;
            r_mode      <= MODE_PASS;
            r_mark      <= '0;
            r_tpr       <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_row_base  <= '0;
            r_out_valid <= 1'b0;
            r_out_pix   <= '0;
            r_out_last  <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_cfg_err <= r_state == IDLE && start && w_cfg_bad;
            if (w_start_ok) begin
                r_width    <= cfg_width;
                r_height   <= cfg_height;
                r_mode     <= cfg_mode;
                r_mark     <= cfg_mark;
                r_tpr      <= (cfg_width + DIM_W'(BLK-1)) >> SH;
                r_x        <= '0;
                r_y        <= '0;
                r_row_base <= '0;
            end
            if (w_acc) begin
                r_x        <= w_x_end ? '0 : r_x + DIM_W'(1);
                r_y        <= w_x_end ? r_y + DIM_W'(1) : r_y;
                r_row_base <= (w_x_end && &r_y[SH-1:0]) ? r_row_base + TA_W'(r_tpr) : r_row_base;
            end
            if (w_acc) begin
                r_out_valid <= 1'b1;
                r_out_pix   <= w_mark ? r_mark : in_pix;
                r_out_last  <= w_x_end && w_y_end;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end

    assign out_valid = r_out_valid;
    assign out_pix   = r_out_pix;
    assign out_last  = r_out_last;
    assign busy      = r_state != IDLE;
    assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_bbox_overlay_stream.sv
// tb_bbox_overlay_stream: directed frames against a scoreboard fed by a tile-level overlay model
module tb_bbox_overlay_stream;

    localparam int PIX_W     = 8;
    localparam int BLK       = 8;
    localparam int MAX_W     = 1024;
    localparam int MAX_H     = 1024;
    localparam int MAX_TILES = (MAX_W/BLK)*(MAX_H/BLK);
    localparam int DIM_W     = 11;
    localparam int TA_W      = 14;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [DIM_W-1:0] cfg_width = '0, cfg_height = '0;
    logic [1:0]       cfg_mode = '0;
    logic [PIX_W-1:0] cfg_mark = '0;
    logic             start = 1'b0, mask_we = 1'b0, mask_din = 1'b0;
    logic [TA_W-1:0]  mask_addr = '0;
    logic             in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [PIX_W-1:0] in_pix = '0, out_pix;
    logic             out_last, busy, frame_done, cfg_err;

    always #5 clk = ~clk;

    bbox_overlay_stream #(
        .PIX_W(PIX_W), .BLK(BLK), .MAX_W(MAX_W), .MAX_H(MAX_H),
        .MAX_TILES(MAX_TILES), .DIM_W(DIM_W), .TA_W(TA_W)
    ) dut (
        .clk(clk), .reset(reset),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_mode(cfg_mode), .cfg_mark(cfg_mark),
        .start(start), .mask_we(mask_we), .mask_addr(mask_addr), .mask_din(mask_din),
        .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
        .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix), .out_last(out_last),
        .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
    );

    int passed = 0, total = 0, failed = 0;
    logic [PIX_W:0] sb[$];
    bit   bm [0:255];
    int   fw, fh, fmode, ftpr;
    logic [PIX_W-1:0] fmark;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit tile_set(input int tx, input int ty);
        if (tx < 0 || ty < 0 || tx*BLK >= fw || ty*BLK >= fh) return 1'b0;
        return bm[ty*ftpr + tx];
    endfunction

    function automatic logic [PIX_W-1:0] ramp(input int x, input int y);
        return PIX_W'(x + 16*y);
    endfunction

    function automatic logic [PIX_W:0] model(input int x, input int y);
        int tx = x / BLK;
        int ty = y / BLK;
        bit hit, on, last;
        hit  = tile_set(tx, ty);
        on   = (x % BLK == 0 && !tile_set(tx-1, ty)) ||
               ((x % BLK == BLK-1 || x == fw-1) && !tile_set(tx+1, ty)) ||
               (y % BLK == 0 && !tile_set(tx, ty-1)) ||
               ((y % BLK == BLK-1 || y == fh-1) && !tile_set(tx, ty+1));
        last = x == fw-1 && y == fh-1;
        return {last, ((fmode == 1 && hit) || (fmode == 2 && hit && on)) ? fmark : ramp(x, y)};
    endfunction

    task automatic write_tile(input int idx, input bit b);
        @(negedge clk);
        mask_we   = 1'b1;
        mask_addr = TA_W'(idx);
        mask_din  = b;
        bm[idx]   = b;
        @(posedge clk);
        #1 mask_we = 1'b0;
    endtask

    task automatic clear_tiles(input int w, input int h);
        for (int i = 0; i < ((w+BLK-1)/BLK)*((h+BLK-1)/BLK); i++) write_tile(i, 1'b0);
    endtask

    task automatic run_frame(input int w, input int h, input int mode, input logic [PIX_W-1:0] mark,
                             input int rpct, input int vpct, input int abort, input int exp_marked);
        int n = 0, got = 0, fd = 0, mk = 0, cyc = 0;
        logic [PIX_W:0] e;
        fw = w; fh = h; fmode = mode; fmark = mark; ftpr = (w + BLK - 1) / BLK;
        sb.delete();
        @(negedge clk);
        cfg_width  = DIM_W'(w);
        cfg_height = DIM_W'(h);
        cfg_mode   = 2'(mode);
        cfg_mark   = mark;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1 check("busy_after_start", busy, 1);
        while (got < w*h && cyc < 5000) begin
            if (abort > 0 && n >= abort) break;
            out_ready = rpct >= 100 || int'($urandom_range(99)) < rpct;
            in_valid  = n < w*h && (vpct >= 100 || int'($urandom_range(99)) < vpct);
            in_pix    = ramp(n % w, n / w);
            #1;
            if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
            if (n == w*h) check("drain_in_ready", in_ready, 0);
            if (frame_done) fd++;
            if (out_valid && out_ready) begin
                check("sb_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("pix", out_pix, e[PIX_W-1:0]);
                    check("last", out_last, e[PIX_W]);
                    if (out_pix != ramp(got % w, got / w)) mk++;
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(n % w, n / w));
                n++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        if (abort > 0) begin
            reset = 1'b1;
            @(negedge clk);
            #1;
            check("rst_out_valid", out_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_in_ready", in_ready, 0);
            reset = 1'b0;
            sb.delete();
        end else begin
            out_ready = 1'b1;
            #1;
            check("frame_complete", got, w*h);
            check("frame_done_count", fd, 1);
            check("busy_after_frame", busy, 0);
            check("frame_done_idle", frame_done, 0);
            check("out_valid_idle", out_valid, 0);
            if (exp_marked >= 0) check("marked_count", mk, exp_marked);
        end
    endtask

    task automatic bad_start(input int w, input int h);
        @(negedge clk);
        cfg_width  = DIM_W'(w);
        cfg_height = DIM_W'(h);
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("cfg_err_pulse", cfg_err, 1);
        check("cfg_err_busy", busy, 0);
        @(negedge clk);
        #1;
        check("cfg_err_cleared", cfg_err, 0);
        check("cfg_err_idle", busy, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 0);
        check("reset_busy", busy, 0);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("idle_out_valid", out_valid, 0);
        check("idle_out_last", out_last, 0);
        check("idle_in_ready", in_ready, 0);
        check("idle_busy", busy, 0);
        check("idle_frame_done", frame_done, 0);
        check("idle_cfg_err", cfg_err, 0);

        clear_tiles(16, 16);
        run_frame(16, 16, 1, 8'hFF, 100, 100, 0, 0);

        clear_tiles(10, 10);
        write_tile(3, 1'b1);
        run_frame(10, 10, 1, 8'hFF, 100, 100, 0, 4);

        clear_tiles(24, 24);
        write_tile(0, 1'b1);
        write_tile(1, 1'b1);
        run_frame(24, 24, 2, 8'hFF, 100, 100, 0, 44);

        clear_tiles(16, 16);
        write_tile(1, 1'b1);
        run_frame(16, 16, 1, 8'hFF, 30, 80, 0, 64);

        bad_start(0, 16);
        bad_start(16, MAX_H + 1);

        run_frame(16, 16, 1, 8'hFF, 100, 100, 50, -1);
        run_frame(16, 16, 1, 8'hFF, 100, 100, 0, 64);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
